// File: rtl/fp_unit_arbiter.sv
// rtl/fp_unit_arbiter.sv - round-robin arbiter sharing one stb/ack FP unit among N_REQ requesters
module fp_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 32,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [W-1:0]       resp_data,
    input  logic [N_REQ-1:0]   resp_ack,
    output logic               unit_rst,
    output logic [W-1:0]       unit_a,
    output logic [W-1:0]       unit_b,
    output logic               unit_a_stb,
    input  logic               unit_a_ack,
    output logic               unit_b_stb,
    input  logic               unit_b_ack,
    input  logic [W-1:0]       unit_z,
    input  logic               unit_z_stb,
    output logic               unit_z_ack,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_SEND_A,
        S_SEND_B,
        S_WAIT_Z,
        S_RESP
    } state_t;

    state_t state, state_d;

    logic [N_REQ-1:0] req_ready_d;
    logic [N_REQ-1:0] resp_valid_d;
    logic [W-1:0]     resp_data_d;
    logic             unit_rst_d;
    logic [W-1:0]     unit_a_d;
    logic [W-1:0]     unit_b_d;
    logic             unit_a_stb_d;
    logic             unit_b_stb_d;
    logic             unit_z_ack_d;
    logic [ID_W-1:0]  grant_id_d;
    logic             busy_d;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  last_grant_d;

    // Rotating priority: scan last_grant+1 .. last_grant+N_REQ, wrapping modulo N_REQ.
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [ID_W:0]   cand;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_grant} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ))
                cand = cand - (ID_W+1)'(N_REQ);
            if (!win_found && req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[ID_W-1:0];
            end
        end
    end

    logic [W-1:0] win_a;
    logic [W-1:0] win_b;

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_a = req_a[i*W +: W];
                win_b = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d      = state;
        req_ready_d  = '0;
        resp_valid_d = resp_valid;
        resp_data_d  = resp_data;
        unit_rst_d   = unit_rst;
        unit_a_d     = unit_a;
        unit_b_d     = unit_b;
        unit_a_stb_d = unit_a_stb;
        unit_b_stb_d = unit_b_stb;
        unit_z_ack_d = unit_z_ack;
        grant_id_d   = grant_id;
        last_grant_d = last_grant;

        case (state)
            S_IDLE: begin
                if (win_found) begin
                    grant_id_d          = win_id;
                    unit_a_d            = win_a;
                    unit_b_d            = win_b;
                    req_ready_d[win_id] = 1'b1;
                    unit_rst_d          = 1'b1;
                    state_d             = S_RESET;
                end
            end
            S_RESET: begin
                unit_rst_d   = 1'b0;
                unit_a_stb_d = 1'b1;
                state_d      = S_SEND_A;
            end
            S_SEND_A: begin
                if (unit_a_ack) begin
                    unit_a_stb_d = 1'b0;
                    unit_b_stb_d = 1'b1;
                    state_d      = S_SEND_B;
                end
            end
            S_SEND_B: begin
                if (unit_b_ack) begin
                    unit_b_stb_d = 1'b0;
                    state_d      = S_WAIT_Z;
                end
            end
            S_WAIT_Z: begin
                if (unit_z_stb) begin
                    resp_data_d            = unit_z;
                    unit_z_ack_d           = 1'b1;
                    resp_valid_d           = '0;
                    resp_valid_d[grant_id] = 1'b1;
                    state_d                = S_RESP;
                end
            end
            S_RESP: begin
                unit_z_ack_d = 1'b0;
                // Only the granted requester's ack releases the result.
                if (resp_ack[grant_id]) begin
                    resp_valid_d = '0;
                    last_grant_d = grant_id;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            unit_rst   <= 1'b1;
            unit_a     <= '0;
            unit_b     <= '0;
            unit_a_stb <= 1'b0;
            unit_b_stb <= 1'b0;
            unit_z_ack <= 1'b0;
            grant_id   <= '0;
            busy       <= 1'b0;
            last_grant <= ID_W'(N_REQ-1);
        end else begin
            state      <= state_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_data  <= resp_data_d;
            unit_rst   <= unit_rst_d;
            unit_a     <= unit_a_d;
            unit_b     <= unit_b_d;
            unit_a_stb <= unit_a_stb_d;
            unit_b_stb <= unit_b_stb_d;
            unit_z_ack <= unit_z_ack_d;
            grant_id   <= grant_id_d;
            busy       <= busy_d;
            last_grant <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb/tb_fp_unit_arbiter.sv - directed scoreboard bench for fp_unit_arbiter with a behavioural FP multiplier
module tb_fp_unit_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_data;
    logic [N-1:0]   resp_ack;
    logic           unit_rst;
    logic [W-1:0]   unit_a;
    logic [W-1:0]   unit_b;
    logic           unit_a_stb;
    logic           unit_a_ack;
    logic           unit_b_stb;
    logic           unit_b_ack;
    logic [W-1:0]   unit_z;
    logic           unit_z_stb;
    logic           unit_z_ack;
    logic [IW-1:0]  grant_id;
    logic           busy;

    always #5 clk = ~clk;

    fp_unit_arbiter #(.N_REQ(N), .W(W), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ack(resp_ack),
        .unit_rst(unit_rst), .unit_a(unit_a), .unit_b(unit_b),
        .unit_a_stb(unit_a_stb), .unit_a_ack(unit_a_ack),
        .unit_b_stb(unit_b_stb), .unit_b_ack(unit_b_ack),
        .unit_z(unit_z), .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack),
        .grant_id(grant_id), .busy(busy)
    );

    // Behavioural stand-in for the shared multiplier: exact for short mantissas.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        int          e;
        logic [22:0] f;
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            e = e + 1;
            f = m[46:24];
        end else begin
            f = m[45:23];
        end
        return {a[31] ^ b[31], e[7:0], f};
    endfunction

    logic        hold_a = 1'b0;
    logic        hold_z = 1'b0;
    logic        spur_z = 1'b0;
    logic        z_stb_m;
    logic [31:0] ua, ub;
    int          m_state, m_cnt;

    assign unit_z_stb = z_stb_m | spur_z;

    always @(posedge clk) begin
        if (unit_rst) begin
            m_state    <= 0;
            unit_a_ack <= 1'b0;
            unit_b_ack <= 1'b0;
            z_stb_m    <= 1'b0;
            m_cnt      <= 0;
        end else begin
            case (m_state)
                0: if (unit_a_ack) begin
                       unit_a_ack <= 1'b0;
                       m_state    <= 1;
                   end else if (unit_a_stb && !hold_a) begin
                       unit_a_ack <= 1'b1;
                       ua         <= unit_a;
                   end
                1: if (unit_b_ack) begin
                       unit_b_ack <= 1'b0;
                       m_state    <= 2;
                       m_cnt      <= 3;
                   end else if (unit_b_stb) begin
                       unit_b_ack <= 1'b1;
                       ub         <= unit_b;
                   end
                2: if (!hold_z) begin
                       if (m_cnt == 0) begin
                           unit_z  <= fp_mul(ua, ub);
                           z_stb_m <= 1'b1;
                           m_state <= 3;
                       end else begin
                           m_cnt <= m_cnt - 1;
                       end
                   end
                3: if (unit_z_ack) begin
                       z_stb_m <= 1'b0;
                       m_state <= 4;
                   end
                default: ;
            endcase
        end
    end

    int onehot_viol = 0;
    always @(negedge clk) begin
        if (!rst && ($countones(req_ready) > 1 || $countones(resp_valid) > 1))
            onehot_viol++;
    end

    typedef struct {
        int          id;
        logic [31:0] z;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int id);
        logic [N-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [31:0] z);
        exp_t e;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id]    = 1'b1;
        e.id = id;
        e.z  = z;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input int id, input bit clr);
        for (int c = 0; c < 50 && req_ready == '0; c++) @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(oh(id)));
        if (clr) req_valid[id] = 1'b0;
    endtask

    task automatic wait_resp();
        exp_t e;
        for (int c = 0; c < 200 && resp_valid == '0; c++) @(negedge clk);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'(resp_valid), 64'd0);
            return;
        end
        e = sb.pop_front();
        chk("resp_valid", 64'(resp_valid), 64'(oh(e.id)));
        chk("resp_data", 64'(resp_data), 64'(e.z));
        chk("grant_id", 64'(grant_id), 64'(e.id));
    endtask

    task automatic ack_resp(input int id);
        resp_ack = oh(id);
        @(negedge clk);
        resp_ack = '0;
    endtask

    int bad_valid, bad_data, bad_busy, bad_grant, stray;

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ack = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_unit_rst", 64'(unit_rst), 64'd1);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_stbs", 64'({unit_a_stb, unit_b_stb, unit_z_ack}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // single request 2.0 * 3.0
        set_req(0, 32'h40000000, 32'h40400000, 32'h40C00000);
        wait_ready(0, 1'b1);
        chk("single_unit_rst_hi", 64'(unit_rst), 64'd1);
        @(negedge clk);
        chk("single_ready_pulse", 64'(req_ready), 64'd0);
        chk("single_unit_rst_lo", 64'(unit_rst), 64'd0);
        chk("single_busy", 64'(busy), 64'd1);
        wait_resp();
        ack_resp(0);
        chk("single_done_valid", 64'(resp_valid), 64'd0);
        chk("single_done_busy", 64'(busy), 64'd0);

        // round robin from fresh priority
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        set_req(0, 32'h40000000, 32'h40400000, 32'h40C00000);
        set_req(1, 32'h3FC00000, 32'h40000000, 32'h40400000);
        set_req(2, 32'h40800000, 32'h3F000000, 32'h40000000);
        set_req(3, 32'hC0000000, 32'h40400000, 32'hC0C00000);
        for (int i = 0; i < 4; i++) begin
            wait_resp();
            ack_resp(i);
        end
        req_valid = 4'b0001;
        begin
            exp_t e;
            e.id = 0;
            e.z  = 32'h40C00000;
            sb.push_back(e);
        end
        wait_ready(0, 1'b1);
        wait_resp();
        ack_resp(0);

        // priority rotation after requester 2
        set_req(2, 32'h40800000, 32'h3F000000, 32'h40000000);
        wait_ready(2, 1'b1);
        wait_resp();
        ack_resp(2);
        set_req(0, 32'h40A00000, 32'h40A00000, 32'h41C80000);
        set_req(2, 32'h40800000, 32'h3F000000, 32'h40000000);
        wait_ready(0, 1'b1);
        wait_resp();
        ack_resp(0);
        wait_ready(2, 1'b1);
        wait_resp();
        ack_resp(2);

        // response backpressure with a pending requester and a stray resp_ack[2]
        set_req(1, 32'h3FC00000, 32'h40000000, 32'h40400000);
        wait_ready(1, 1'b1);
        set_req(3, 32'hC0000000, 32'h40400000, 32'hC0C00000);
        wait_resp();
        bad_valid = 0; bad_data = 0; bad_busy = 0; bad_grant = 0;
        for (int c = 0; c < 20; c++) begin
            resp_ack = (c == 10) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (resp_valid !== 4'b0010) bad_valid++;
            if (resp_data !== 32'h40400000) bad_data++;
            if (busy !== 1'b1) bad_busy++;
            if (req_ready !== 4'b0000) bad_grant++;
        end
        resp_ack = '0;
        chk("bp_valid_unstable", 64'(bad_valid), 64'd0);
        chk("bp_data_unstable", 64'(bad_data), 64'd0);
        chk("bp_busy_dropped", 64'(bad_busy), 64'd0);
        chk("bp_new_grant", 64'(bad_grant), 64'd0);
        ack_resp(1);
        wait_ready(3, 1'b1);
        wait_resp();
        ack_resp(3);

        // spurious unit_z_stb while sending A
        hold_a = 1'b1;
        set_req(0, 32'h40A00000, 32'h40A00000, 32'h41C80000);
        wait_ready(0, 1'b1);
        repeat (2) @(negedge clk);
        spur_z = 1'b1;
        @(negedge clk);
        spur_z = 1'b0;
        @(negedge clk);
        chk("spur_a_stb", 64'(unit_a_stb), 64'd1);
        chk("spur_b_stb", 64'(unit_b_stb), 64'd0);
        chk("spur_z_ack", 64'(unit_z_ack), 64'd0);
        chk("spur_resp_valid", 64'(resp_valid), 64'd0);
        chk("spur_resp_data", 64'(resp_data), 64'hC0C00000);
        hold_a = 1'b0;
        wait_resp();
        ack_resp(0);

        // reset while waiting for the result
        hold_z = 1'b1;
        req_a[2*W +: W] = 32'h40800000;
        req_b[2*W +: W] = 32'h3F000000;
        req_valid[2] = 1'b1;
        wait_ready(2, 1'b1);
        repeat (8) @(negedge clk);
        chk("midrst_in_wait_z", 64'({busy, unit_a_stb, unit_b_stb}), 64'b100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_unit_rst", 64'(unit_rst), 64'd1);
        chk("midrst_resp", 64'({resp_valid, resp_data}), 64'd0);
        chk("midrst_unit_ab", 64'({unit_a, unit_b}), 64'd0);
        chk("midrst_grant_id", 64'(grant_id), 64'd0);
        hold_z = 1'b0;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_valid !== '0) stray++;
        end
        chk("midrst_no_resp", 64'(stray), 64'd0);
        set_req(3, 32'h3FC00000, 32'h40800000, 32'h40C00000);
        wait_ready(3, 1'b1);
        wait_resp();
        ack_resp(3);
        chk("final_busy", 64'(busy), 64'd0);
        chk("onehot", 64'(onehot_viol), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Round-robin arbiter that shares one stb/ack-handshaked single-precision floating-point unit (the team's `multiplier` or `adder`) between N_REQ requesters.
- Each granted operation is sequenced as follows:
  - pulse the unit's reset;
  - send operand A, then operand B;
  - collect the result;
  - return the result to the granted requester.
- Sits between several matrix-multiplier datapaths and a single shared FP core, so the core is instantiated once.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 32, operand/result width.
- ID_W, $clog2(N_REQ), grant index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  requester i has an operation pending; held high until req_ready[i] is seen.
- req_a  in  N_REQ*W  operand A of requester i, in bits [i*W +: W].
- req_b  in  N_REQ*W  operand B of requester i, in bits [i*W +: W].
- req_ready  out  N_REQ  one-cycle pulse: operands of requester i have been latched.
- resp_valid  out  N_REQ  result available for requester i; held until resp_ack[i].
- resp_data  out  W  result, shared by all requesters; valid when any resp_valid bit is high.
- resp_ack  in  N_REQ  requester i accepts the result.
- unit_rst  out  1  reset to the FP unit.
- unit_a  out  W  operand A to the FP unit.
- unit_b  out  W  operand B to the FP unit.
- unit_a_stb  out  1  operand A strobe.
- unit_a_ack  in  1  operand A acknowledge.
- unit_b_stb  out  1  operand B strobe.
- unit_b_ack  in  1  operand B acknowledge.
- unit_z  in  W  result from the FP unit.
- unit_z_stb  in  1  result strobe.
- unit_z_ack  out  1  result acknowledge.
- grant_id  out  ID_W  index of the current or last granted requester.
- busy  out  1  high in every state except S_IDLE.

Behaviour:
- Reset (rst high at a rising edge of clk):
  - state=S_IDLE.
  - req_ready=0, resp_valid=0, resp_data=0.
  - unit_a=0, unit_b=0, unit_a_stb=0, unit_b_stb=0, unit_z_ack=0.
  - unit_rst=1, held until the first grant.
  - grant_id=0, busy=0.
  - last_grant=N_REQ-1, so requester 0 has first priority.
  - Reset mid-operation aborts the operation and discards it; no resp_valid is issued for it.
- All outputs are registered.
- S_IDLE:
  - If any req_valid bit is high, pick the winner: the first set bit scanning last_grant+1, last_grant+2, ... with wrap-around modulo N_REQ.
  - At the same edge: grant_id<=winner; unit_a/unit_b<=that requester's operands; req_ready[winner]<=1; unit_rst<=1; go to S_RESET.
  - req_valid is sampled only in S_IDLE.
- S_RESET (one cycle): req_ready<=0, unit_rst<=0, unit_a_stb<=1, go to S_SEND_A.
- S_SEND_A: hold unit_a_stb. On the cycle unit_a_ack is seen, set unit_a_stb<=0 and unit_b_stb<=1, and go to S_SEND_B.
- S_SEND_B: hold unit_b_stb. On unit_b_ack, set unit_b_stb<=0 and go to S_WAIT_Z.
- S_WAIT_Z:
  - On unit_z_stb: resp_data<=unit_z; unit_z_ack<=1 for exactly one cycle; resp_valid[grant_id]<=1; go to S_RESP.
- S_RESP:
  - unit_z_ack<=0.
  - Hold resp_valid[grant_id] and resp_data until resp_ack[grant_id] is sampled high.
  - Then resp_valid<=0, last_grant<=grant_id, go to S_IDLE.
  - resp_ack bits other than resp_ack[grant_id] are ignored.
- Only one operation is in flight at a time. At most one bit of req_ready is high, and at most one bit of resp_valid is high.
- Minimum latency, with zero-wait acks from the unit and the requester:
  - req_ready at cycle 1 after the grant edge;
  - resp_valid at (FP unit latency + 4) cycles after the grant edge.
- S_RESP returns to S_IDLE, then to the next grant, so back-to-back grants are separated by at least two idle/reset cycles.
- Fairness: a requester that holds req_valid is granted within N_REQ grants.
- A requester may re-assert req_valid while its previous response is pending. It is arbitrated normally once state returns to S_IDLE.
- Acks that arrive outside their waiting state (spurious unit_a_ack, unit_b_ack, unit_z_stb or resp_ack) are ignored.
- No timeout: a stalled unit holds the FSM in its current state indefinitely, with busy=1.

Test Plan:
- Single request: req_valid=4'b0001, A=32'h40000000 (2.0), B=32'h40400000 (3.0), shared unit is the `multiplier`.
  - Expected: req_ready[0] pulses for exactly one cycle; unit_rst pulses for one cycle; resp_valid[0]=1 with resp_data=32'h40C00000 (6.0).
  - After resp_ack[0]: resp_valid=0 and busy=0.
- Round-robin: req_valid=4'b1111 held continuously, each requester re-asserting after its response.
  - Expected: grant order is 0,1,2,3,0, and each requester's result is correct for its own operands.
- Priority rotation: after requester 2 has been served, assert req_valid=4'b0101.
  - Expected: requester 0 is granted next; requester 2 is granted after that.
- Response backpressure: hold resp_ack[1]=0 for 20 cycles.
  - Expected: resp_valid[1] and resp_data stay stable; no new grant is made; busy=1.
  - Deasserting the hold and asserting resp_ack[1] releases the FSM.
- Mid-operation reset: assert rst for one cycle while in S_WAIT_Z.
  - Expected next cycle: state is idle, all outputs are at their reset values, unit_rst=1, and no resp_valid is issued.
  - A later request from requester 3 is then served correctly.
- Spurious acks: pulse unit_z_stb in S_SEND_A, and pulse resp_ack[2] while requester 1 is the one granted.
  - Expected: no state change, and no corruption of resp_data.
